// File: rtl/mmio_io_hub.sv
// Memory-mapped I/O hub: CPU clock-enable, hex/control registers, button debounce, run latch.
// Optional MMIO_HEX_DECODE_EN registers a 7-segment decode of the digits onto seg.
module mmio_io_hub #(
    parameter int                  ADDR_W      = 16,
    parameter int                  DATA_W      = 32,
    parameter int                  NUM_DIGITS  = 4,
    parameter int                  NUM_BUTTONS = 3,
    parameter logic [ADDR_W-1:0]   HEX_ADDR    = 16'hFFFF,
    parameter logic [ADDR_W-1:0]   CTRL_ADDR   = 16'hFFFE,
    parameter int                  DIV         = 4,
    parameter int                  DEBOUNCE    = 16
) (
    input  logic                     clock,
    input  logic                     Rst,
    input  logic [ADDR_W-1:0]        address,
    input  logic [DATA_W-1:0]        data,
    input  logic                     wren,
    output logic                     cpu_en,
    output logic [DATA_W-1:0]        rdata,
    output logic                     hit,
    output logic [4*NUM_DIGITS-1:0]  digits,
    output logic [7*NUM_DIGITS-1:0]  seg,
    input  logic [NUM_BUTTONS-1:0]   buttons,
    output logic [NUM_BUTTONS-1:0]   btn_state,
    output logic [NUM_BUTTONS-1:0]   btn_press,
    output logic                     cpu_nrst
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic [PW-1:0]             pres_q, pres_d;
    logic                      cpu_en_q;
    logic [DATA_W-1:0]         rdata_q, rdata_d;
    logic                      hit_q, hit_d;
    logic [4*NUM_DIGITS-1:0]   digits_q;
    logic [NUM_DIGITS-1:0]     blank_q;
    logic [NUM_BUTTONS-1:0]    sync1_q, sync2_q, pressed;
    logic [NUM_BUTTONS-1:0]    btn_state_q, btn_press_q, flip;
    logic                      cpu_nrst_q;
    logic                      we;
    logic                      unused_data;

    assign unused_data = ^data;

    // cpu_en is registered, so it is computed from the count the prescaler is about to hold
    assign pres_d = (pres_q == PW'(DIV - 1)) ? '0 : pres_q + 1'b1;
    assign we     = wren & cpu_en_q;
    assign pressed = ~sync2_q;

    always_comb begin
        rdata_d = '0;
        hit_d   = 1'b0;
        if (address == HEX_ADDR) begin
            rdata_d[4*NUM_DIGITS-1:0] = digits_q;
            hit_d = 1'b1;
        end else if (address == CTRL_ADDR) begin
            rdata_d[NUM_DIGITS+NUM_BUTTONS:0] = {cpu_nrst_q, btn_state_q, blank_q};
            hit_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (Rst) begin
            pres_q      <= '0;
            cpu_en_q    <= 1'b0;
            rdata_q     <= '0;
            hit_q       <= 1'b0;
            digits_q    <= '0;
            blank_q     <= '0;
            sync1_q     <= '1;
            sync2_q     <= '1;
            btn_state_q <= '0;
            btn_press_q <= '0;
            cpu_nrst_q  <= 1'b0;
        end else begin
            pres_q      <= pres_d;
            cpu_en_q    <= (pres_d == PW'(DIV - 1));
            rdata_q     <= rdata_d;
            hit_q       <= hit_d;
            if (we && address == HEX_ADDR)
                digits_q <= data[4*NUM_DIGITS-1:0];
            if (we && address == CTRL_ADDR)
                blank_q <= data[NUM_DIGITS-1:0];
            sync1_q     <= buttons;
            sync2_q     <= sync1_q;
            btn_state_q <= btn_state_q ^ flip;
            btn_press_q <= flip & ~btn_state_q;
            // halt has priority over run when both are accepted together
            if (btn_press_q[1])
                cpu_nrst_q <= 1'b0;
            else if (btn_press_q[0])
                cpu_nrst_q <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_db
            logic [CW-1:0] cnt_q;
            logic          differ;
            assign differ   = pressed[gi] != btn_state_q[gi];
            assign flip[gi] = differ && (cnt_q == CW'(DEBOUNCE - 1));
            always_ff @(posedge clock) begin
                if (Rst)
                    cnt_q <= '0;
                else if (differ && !flip[gi])
                    cnt_q <= cnt_q + 1'b1;
                else
                    cnt_q <= '0;
            end
        end
    endgenerate

`ifdef MMIO_HEX_DECODE_EN
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    logic [7*NUM_DIGITS-1:0] seg_q, seg_d;

    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_seg
            assign seg_d[7*gi +: 7] = blank_q[gi] ? 7'b1111111 : hex7(digits_q[4*gi +: 4]);
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (Rst)
            seg_q <= '1;
        else
            seg_q <= seg_d;
    end

    assign seg = seg_q;
`else
    assign seg = '1;
`endif

    assign cpu_en    = cpu_en_q;
    assign rdata     = rdata_q;
    assign hit       = hit_q;
    assign digits    = digits_q;
    assign btn_state = btn_state_q;
    assign btn_press = btn_press_q;
    assign cpu_nrst  = cpu_nrst_q;
endmodule

// File: tb/tb_mmio_io_hub.sv
// Directed + randomized bench for mmio_io_hub against a cycle-level reference model.
module tb_mmio_io_hub;
    localparam int ND = 4;
    localparam int NB = 3;
    localparam int DV = 4;
    localparam int DB = 16;
    localparam logic [15:0] HEXA  = 16'hFFFF;
    localparam logic [15:0] CTRLA = 16'hFFFE;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        wren;
    logic [2:0]  btn;

    logic        en_o, hit_o, nrst_o;
    logic [31:0] rdata_o;
    logic [15:0] digits_o;
    logic [27:0] seg_o;
    logic [2:0]  state_o, press_o;

    logic        en1, hit1, nrst1;
    logic [31:0] rdata1;
    logic [15:0] digits1;
    logic [27:0] seg1;
    logic [2:0]  state1, press1;

    mmio_io_hub dut (
        .clock(clk), .Rst(rst), .address(addr), .data(wdata), .wren(wren),
        .cpu_en(en_o), .rdata(rdata_o), .hit(hit_o), .digits(digits_o), .seg(seg_o),
        .buttons(btn), .btn_state(state_o), .btn_press(press_o), .cpu_nrst(nrst_o)
    );

    mmio_io_hub #(.DIV(1)) dut1 (
        .clock(clk), .Rst(rst), .address(16'h0000), .data(32'h0), .wren(1'b0),
        .cpu_en(en1), .rdata(rdata1), .hit(hit1), .digits(digits1), .seg(seg1),
        .buttons(3'b111), .btn_state(state1), .btn_press(press1), .cpu_nrst(nrst1)
    );

    // reference model state, valid after each clock edge
    int          k = 0;
    int          c = 0;
    logic        m_en = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        m_hit = 1'b0;
    logic [15:0] m_digits = '0;
    logic [3:0]  m_blank = '0;
    logic [2:0]  m_state = '0;
    logic [2:0]  m_press = '0;
    logic        m_nrst = 1'b0;
    logic [27:0] m_seg = '1;
    logic [2:0]  pipe1 = '1;
    logic [2:0]  pipe2 = '1;
    bit          samp [3][8192];
    int          base [3];
    int          n_cmp = 0;
    int          n_bad = 0;

    logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h (edge %0d)", tag, obs, exp, k);
        end
    endtask

    task automatic model_edge();
        logic [31:0] rd;
        logic        ht;
        logic [2:0]  flip;
        logic [27:0] sg;
        if (rst) begin
            c = 0; m_en = 0; m_rdata = '0; m_hit = 0; m_digits = '0; m_blank = '0;
            m_state = '0; m_press = '0; m_nrst = 0; m_seg = '1; pipe1 = '1; pipe2 = '1;
            for (int b = 0; b < NB; b++) base[b] = k;
        end else begin
            rd = '0; ht = 0;
            if (addr == HEXA) begin rd = {16'h0, m_digits}; ht = 1; end
            else if (addr == CTRLA) begin rd = {24'h0, m_nrst, m_state, m_blank}; ht = 1; end
            sg = '1;
`ifdef MMIO_HEX_DECODE_EN
            for (int d = 0; d < ND; d++)
                if (!m_blank[d]) sg[7*d +: 7] = seg_tab[m_digits[4*d +: 4]];
`endif
            m_seg = sg;
            if (m_press[1]) m_nrst = 0;
            else if (m_press[0]) m_nrst = 1;
            if (wren && m_en && addr == HEXA)  m_digits = wdata[15:0];
            if (wren && m_en && addr == CTRLA) m_blank  = wdata[3:0];
            for (int b = 0; b < NB; b++) begin
                samp[b][k] = ~pipe2[b];
                flip[b] = 0;
                // accept only after DB consecutive post-change samples disagree with the state
                if (k - base[b] >= DB) begin
                    flip[b] = 1;
                    for (int j = 0; j < DB; j++)
                        if (samp[b][k-j] == m_state[b]) flip[b] = 0;
                end
                if (flip[b]) base[b] = k;
            end
            m_press = flip & ~m_state;
            m_state = m_state ^ flip;
            m_rdata = rd; m_hit = ht;
            pipe2 = pipe1; pipe1 = btn;
            c++;
            m_en = (c % DV) == DV - 1;
        end
        k++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        chk("cpu_en", {31'h0, en_o}, {31'h0, m_en});
        chk("rdata", rdata_o, m_rdata);
        chk("hit", {31'h0, hit_o}, {31'h0, m_hit});
        chk("digits", {16'h0, digits_o}, {16'h0, m_digits});
        chk("seg", {4'h0, seg_o}, {4'h0, m_seg});
        chk("btn_state", {29'h0, state_o}, {29'h0, m_state});
        chk("btn_press", {29'h0, press_o}, {29'h0, m_press});
        chk("cpu_nrst", {31'h0, nrst_o}, {31'h0, m_nrst});
        if (c >= 1) chk("cpu_en_div1", {31'h0, en1}, 32'h1);
    endtask

    task automatic wait_en_low();
        for (int i = 0; i < 8 && m_en; i++) step();
    endtask

    initial begin
        rst = 1; addr = '0; wdata = '0; wren = 0; btn = 3'b111;
        repeat (3) step();
        chk("rst_nrst", {31'h0, nrst_o}, 32'h0);
        chk("rst_digits", {16'h0, digits_o}, 32'h0);
        rst = 0;
        repeat (12) step();

        // hex write held across a cpu_en pulse, then read back
        addr = HEXA; wdata = 32'h0000BEEF; wren = 1;
        repeat (DV) step();
        wren = 0;
        step();
        chk("beef_digits", {16'h0, digits_o}, 32'h0000BEEF);
        step();
        chk("beef_rdata", rdata_o, 32'h0000BEEF);
        chk("beef_hit", {31'h0, hit_o}, 32'h1);
        wait_en_low();
        wdata = 32'h00001111; wren = 1;
        step();
        wren = 0;
        step();
        chk("noen_digits", {16'h0, digits_o}, 32'h0000BEEF);

        addr = CTRLA; wdata = 32'h5; wren = 1;
        repeat (DV) step();
        wren = 0;
        repeat (2) step();
        chk("blank_rd", rdata_o & 32'hF, 32'h5);

        // short glitch on run button is ignored
        btn[0] = 0; repeat (10) step();
        btn[0] = 1; repeat (25) step();
        chk("glitch_state", {29'h0, state_o}, 32'h0);
        chk("glitch_nrst", {31'h0, nrst_o}, 32'h0);
        btn[0] = 0;
        repeat (17) step();
        chk("pre_accept", {31'h0, state_o[0]}, 32'h0);
        step();
        chk("accept18", {31'h0, state_o[0]}, 32'h1);
        chk("press_pulse", {31'h0, press_o[0]}, 32'h1);
        step();
        chk("press_single", {31'h0, press_o[0]}, 32'h0);
        step();
        chk("run_set", {31'h0, nrst_o}, 32'h1);
        btn[0] = 1; repeat (25) step();

        // simultaneous run+halt: halt wins
        btn[1:0] = 2'b00; repeat (22) step();
        chk("halt_wins", {31'h0, nrst_o}, 32'h0);
        btn = 3'b111; repeat (25) step();

        // reset while running and mid-debounce
        btn[0] = 0; repeat (22) step();
        btn[0] = 1; repeat (25) step();
        chk("run_again", {31'h0, nrst_o}, 32'h1);
        btn[2] = 0; repeat (8) step();
        rst = 1; step(); rst = 0;
        chk("rst_mid_nrst", {31'h0, nrst_o}, 32'h0);
        chk("rst_mid_state", {29'h0, state_o}, 32'h0);
        repeat (17) step();
        chk("restart_pre", {31'h0, state_o[2]}, 32'h0);
        step();
        chk("restart_acc", {31'h0, state_o[2]}, 32'h1);
        btn[2] = 1; repeat (20) step();

        // unmapped address: reads zero, writes ignored
        addr = HEXA; wdata = 32'h0000CAFE; wren = 1; repeat (DV) step();
        addr = 16'h1234; wdata = 32'hFFFFFFFF; repeat (DV) step();
        wren = 0; step();
        chk("unmap_rdata", rdata_o, 32'h0);
        chk("unmap_hit", {31'h0, hit_o}, 32'h0);
        chk("unmap_digits", {16'h0, digits_o}, 32'h0000CAFE);

        for (int i = 0; i < 700; i++) begin
            case ($urandom_range(0, 3))
                0: addr = HEXA;
                1: addr = CTRLA;
                default: addr = 16'($urandom);
            endcase
            wdata = $urandom;
            wren  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) btn[$urandom_range(0, 2)] ^= 1'b1;
            rst = ($urandom_range(0, 249) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
